// File: rtl/cnn_psum_accumulator.sv
// Per-pixel partial-sum accumulator behind the input-channel adder tree.
// Sums a configurable group of partial sums, adds bias, rescales, applies optional ReLU and saturates.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

package cnn_psum_accumulator_pkg;
   typedef enum logic [1:0] {
      INVALID = 2'd0,
      VALID   = 2'd1,
      LAST    = 2'd2,
      DONE    = 2'd3
   } pe_state_t;
endpackage

module cnn_psum_accumulator
   import cnn_psum_accumulator_pkg::*;
#(
   parameter int DATA_WID   = `CNN_XLEN,
   parameter int CNT_WID    = 8,
   parameter int ACC_WID    = DATA_WID + CNT_WID,
   parameter int FRAC_SHIFT = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  pe_state_t                  status_in,
   input  logic signed [DATA_WID-1:0] data_in,
   input  logic [CNT_WID-1:0]         cfg_acc_len,
   input  logic signed [DATA_WID-1:0] cfg_bias,
   input  logic                       cfg_relu_en,
   input  logic                       flush,
   output pe_state_t                  status_out,
   output logic signed [DATA_WID-1:0] data_out,
   output logic                       acc_busy
);

   localparam int SUM_WID = ACC_WID + 1;
   localparam logic signed [SUM_WID-1:0] SAT_MAX =
      {{(SUM_WID-DATA_WID+1){1'b0}}, {(DATA_WID-1){1'b1}}};
   localparam logic signed [SUM_WID-1:0] SAT_MIN =
      {{(SUM_WID-DATA_WID+1){1'b1}}, {(DATA_WID-1){1'b0}}};

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                      state_q, state_d;
   logic signed [ACC_WID-1:0]   acc_q, acc_d;
   logic [CNT_WID-1:0]          cnt_q, cnt_d;
   logic [CNT_WID-1:0]          len_q, len_d;
   logic signed [DATA_WID-1:0]  bias_q, bias_d;
   logic                        relu_q, relu_d;
   pe_state_t                   status_out_q, status_out_d;
   logic signed [DATA_WID-1:0]  data_out_q, data_out_d;

   logic                        in_valid;
   logic [CNT_WID-1:0]          cfg_len_eff;
   logic signed [ACC_WID-1:0]   acc_base;
   logic signed [DATA_WID-1:0]  fin_bias;
   logic                        fin_relu;
   logic signed [SUM_WID-1:0]   sum_biased;
   logic signed [SUM_WID-1:0]   sum_scaled;
   logic signed [SUM_WID-1:0]   sum_relu;
   logic signed [SUM_WID-1:0]   sum_sat;
   logic                        emit;

   assign in_valid    = (status_in != INVALID);
   assign cfg_len_eff = (cfg_acc_len == '0) ? CNT_WID'(1) : cfg_acc_len;

   // A length-1 group closes in IDLE, so the result path must use live cfg there.
   assign acc_base = (state_q == ACCUM) ? acc_q  : '0;
   assign fin_bias = (state_q == ACCUM) ? bias_q : cfg_bias;
   assign fin_relu = (state_q == ACCUM) ? relu_q : cfg_relu_en;

   assign sum_biased = SUM_WID'(acc_base) + SUM_WID'(data_in) + SUM_WID'(fin_bias);

   generate
      if (FRAC_SHIFT > 0) begin : g_round
         localparam logic signed [SUM_WID-1:0] RND = SUM_WID'(1) << (FRAC_SHIFT - 1);
         assign sum_scaled = (sum_biased + RND) >>> FRAC_SHIFT;
      end else begin : g_no_round
         assign sum_scaled = sum_biased;
      end
   endgenerate

   assign sum_relu = (fin_relu && (sum_scaled < 0)) ? '0 : sum_scaled;
   assign sum_sat  = (sum_relu > SAT_MAX) ? SAT_MAX :
                     (sum_relu < SAT_MIN) ? SAT_MIN : sum_relu;

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      bias_d       = bias_q;
      relu_d       = relu_q;
      status_out_d = INVALID;
      data_out_d   = data_out_q;
      emit         = 1'b0;

      // Flush beats a coincident valid input; in IDLE it only drops that input.
      if (flush) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end else if (in_valid) begin
         case (state_q)
            IDLE: begin
               len_d  = cfg_len_eff;
               bias_d = cfg_bias;
               relu_d = cfg_relu_en;
               if (cfg_len_eff == CNT_WID'(1)) begin
                  emit = 1'b1;
               end else begin
                  acc_d   = ACC_WID'(data_in);
                  cnt_d   = CNT_WID'(1);
                  state_d = ACCUM;
               end
            end
            ACCUM: begin
               if (cnt_q == len_q - CNT_WID'(1)) begin
                  emit    = 1'b1;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  acc_d = acc_q + ACC_WID'(data_in);
                  cnt_d = cnt_q + CNT_WID'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (emit) begin
         status_out_d = status_in;
         data_out_d   = sum_sat[DATA_WID-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         len_q        <= '0;
         bias_q       <= '0;
         relu_q       <= 1'b0;
         status_out_q <= INVALID;
         data_out_q   <= '0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         bias_q       <= bias_d;
         relu_q       <= relu_d;
         status_out_q <= status_out_d;
         data_out_q   <= data_out_d;
      end
   end

   assign status_out = status_out_q;
   assign data_out   = data_out_q;
   assign acc_busy   = (state_q == ACCUM);

endmodule
